// File: rtl/modmul_pipe.sv
// Multi-lane pipelined modular multiplier / multiply-accumulator.
// Each lane computes (A*B) mod Q or (A*B + C) mod Q, fully reduced to [0, Q-1].
// The lanes share one elastic valid/ready handshake across LAT register stages.
// Stage 0 holds the exact product-plus-addend for each lane.
// Middle stages carry that sum forward unchanged.
// The Barrett reduction sits in front of the last stage, which drives R.
module modmul_pipe #(
  parameter int W     = 12,
  parameter int Q     = 3329,
  parameter int LANES = 2,
  parameter int LAT   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [LANES*W-1:0] A,
  input  logic [LANES*W-1:0] B,
  input  logic [LANES*W-1:0] C,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] R
);

  // One spare bit over 2W keeps A*B + C exact for every W-bit input.
  localparam int SW = 2 * W + 1;
  localparam logic [SW:0] Q_EXT = (SW+1)'(Q);
  localparam logic [SW:0] TWO_K = {1'b1, {SW{1'b0}}};
  // Barrett constant floor(2^SW / Q).
  // For any x < 2^SW, the quotient estimate is at most two below the true quotient.
  localparam logic [SW:0] BAR_M = TWO_K / Q_EXT;

  logic [LAT-1:0]       v_r;
  logic [LAT-1:0]       en_s;
  logic [LANES*SW-1:0]  sum_r [LAT-1];
  logic [LANES*SW-1:0]  sum_in_s;
  logic [LANES*W-1:0]   red_s;

  // Per-lane datapath: exact sum feeding stage 0, and Barrett reduction feeding the last stage.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W-1:0]      a_s;
    logic [W-1:0]      b_s;
    logic [W-1:0]      c_s;
    logic [SW-1:0]     x_s;
    logic [2*SW+1:0]   xm_s;
    logic [SW:0]       q_s;
    logic [SW:0]       r0_s;
    logic [SW:0]       r1_s;
    logic [SW:0]       r2_s;
    logic              unused_lane_s;

    assign a_s = A[l*W +: W];
    assign b_s = B[l*W +: W];
    assign c_s = C[l*W +: W];
    // mode is folded into the sum here, so it travels with its beat for free.
    assign sum_in_s[l*SW +: SW] = SW'(a_s) * SW'(b_s) + (SW'(c_s) & {SW{mode}});

    assign x_s  = sum_r[LAT-2][l*SW +: SW];
    assign xm_s = (2*SW+2)'(x_s) * (2*SW+2)'(BAR_M);
    assign q_s  = xm_s[SW +: SW+1];
    // The true remainder is non-negative and below 3Q, so wrap-around subtraction is exact.
    assign r0_s = (SW+1)'(x_s) - q_s * Q_EXT;
    assign r1_s = (r0_s >= Q_EXT) ? (r0_s - Q_EXT) : r0_s;
    assign r2_s = (r1_s >= Q_EXT) ? (r1_s - Q_EXT) : r1_s;
    assign red_s[l*W +: W] = r2_s[W-1:0];
    assign unused_lane_s = ^{xm_s[SW-1:0], xm_s[2*SW+1], r2_s[SW:W]};
  end

  // Stage enables: a stage may load when it, or any stage after it, has a free slot, or when the output drains.
  always_comb begin
    logic chain_s;
    en_s    = {LAT{1'b0}};
    chain_s = out_ready;
    for (int k = LAT - 1; k >= 0; k--) begin
      chain_s = chain_s | !v_r[k];
      en_s[k] = chain_s;
    end
  end

  assign in_ready  = en_s[0];
  assign out_valid = v_r[LAT-1];

  // Pipeline registers: valid bits always move with their enable, data only when a beat arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= {LAT{1'b0}};
      for (int k = 0; k < LAT - 1; k++) begin
        sum_r[k] <= {(LANES*SW){1'b0}};
      end
      R <= {(LANES*W){1'b0}};
    end else begin
      if (en_s[0]) begin
        v_r[0] <= in_valid;
        if (in_valid) begin
          sum_r[0] <= sum_in_s;
        end
      end
      for (int k = 1; k < LAT - 1; k++) begin
        if (en_s[k]) begin
          v_r[k] <= v_r[k-1];
          if (v_r[k-1]) begin
            sum_r[k] <= sum_r[k-1];
          end
        end
      end
      if (en_s[LAT-1]) begin
        v_r[LAT-1] <= v_r[LAT-2];
        if (v_r[LAT-2]) begin
          R <= red_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_modmul_pipe.sv
// Self-checking bench for modmul_pipe (Kyber defaults, two lanes).
// Inputs are driven 1 ns after the rising edge; the DUT is observed on the falling edge.
// Expected results are queued when a beat is accepted and popped when a result leaves.
module tb_modmul_pipe;

  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int LANES = 2;
  localparam int LAT   = 3;
  localparam int BW    = LANES * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [BW-1:0] A;
  logic [BW-1:0] B;
  logic [BW-1:0] C;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] R;

  modmul_pipe #(.W(W), .Q(Q), .LANES(LANES), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .A(A), .B(B), .C(C), .out_valid(out_valid), .out_ready(out_ready), .R(R)
  );

  always #5 clk = ~clk;

  typedef struct { logic [BW-1:0] r; int t; } sb_t;
  typedef struct { logic m; logic [BW-1:0] a; logic [BW-1:0] b; logic [BW-1:0] c; logic [BW-1:0] r; } vec_t;

  sb_t           sbq[$];
  vec_t          vecs[7];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            n_out   = 0;
  logic          stall_prev = 1'b0;
  logic [BW-1:0] r_prev  = '0;
  logic [BW-1:0] cur_exp = '0;
  logic          lat_chk = 1'b0;
  logic          acc_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] model(input logic m, input logic [BW-1:0] a,
                                          input logic [BW-1:0] b, input logic [BW-1:0] c);
    logic [BW-1:0]   r;
    longint unsigned s;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      s = 64'(a[l*W +: W]) * 64'(b[l*W +: W]);
      if (m) s = s + 64'(c[l*W +: W]);
      r[l*W +: W] = W'(s % 64'(Q));
    end
    return r;
  endfunction

  task automatic monitor();
    sb_t e;
    if (rst) begin
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_R", 64'(R), 64'd0);
      stall_prev = 1'b0;
      acc_last   = 1'b0;
      return;
    end
    if (stall_prev) begin
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_R", 64'(R), 64'(r_prev));
    end
    acc_last = in_valid && in_ready;
    if (acc_last) sbq.push_back('{cur_exp, cyc});
    if (out_valid && out_ready) begin
      n_out++;
      if (sbq.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("result", 64'(R), 64'(e.r));
        if (lat_chk) chk("latency", 64'(cyc - e.t), 64'(LAT));
      end
    end
    stall_prev = out_valid && !out_ready;
    r_prev     = R;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic m, input logic [BW-1:0] a, input logic [BW-1:0] b,
                      input logic [BW-1:0] c, input logic [BW-1:0] exp, input logic rnd_ready);
    mode = m; A = a; B = b; C = c; cur_exp = exp; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rnd_ready) out_ready = ($urandom_range(3) != 0);
      tick();
      if (acc_last) return;
    end
    chk("accept_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (sbq.size() == 0) return;
      tick();
    end
    chk("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  function automatic logic [BW-1:0] rnd_op();
    logic [BW-1:0] v;
    v = BW'($urandom());
    if ($urandom_range(7) == 0) v = '1;
    return v;
  endfunction

  initial begin
    logic [BW-1:0] ra, rb, rc, bexp;
    logic          rm;
    logic [BW-1:0] ba[10], bb[10], bc[10];
    logic          bm[10];
    int            idx, base;

    vecs[0] = '{1'b0, {12'd2, 12'd3328},    {12'd3, 12'd3328},    {12'd0, 12'd0},       {12'd6, 12'd1}};
    vecs[1] = '{1'b0, {12'd3329, 12'd4095}, {12'd5, 12'd4095},    {12'd0, 12'd0},       {12'd0, 12'd852}};
    vecs[2] = '{1'b0, {12'd1, 12'd0},       {12'd4095, 12'd3328}, {12'd0, 12'd0},       {12'd766, 12'd0}};
    vecs[3] = '{1'b1, {12'd0, 12'd1000},    {12'd0, 12'd1000},    {12'd4095, 12'd3328}, {12'd766, 12'd1299}};
    vecs[4] = '{1'b1, {12'd3328, 12'd0},    {12'd3328, 12'd0},    {12'd3328, 12'd4095}, {12'd0, 12'd766}};
    vecs[5] = '{1'b0, {12'd3328, 12'd2},    {12'd1, 12'd2},       {12'd5, 12'd100},     {12'd3328, 12'd4}};
    vecs[6] = '{1'b1, {12'd1, 12'd4095},    {12'd1, 12'd4095},    {12'd0, 12'd4095},    {12'd1, 12'd1618}};

    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; A = '0; B = '0; C = '0; out_ready = 1'b1;
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    chk("out_valid_after_reset", 64'(out_valid), 64'd0);
    chk("R_after_reset", 64'(R), 64'd0);

    // Directed corner vectors, back to back, mixed modes.
    lat_chk = 1'b1;
    for (int i = 0; i < 7; i++) send(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].r, 1'b0);
    drain();
    repeat (2) tick();
    chk("hold_R_after_drain", 64'(R), 64'(vecs[6].r));

    // Backpressure: 10 beats offered while the output is stalled for 6 cycles.
    lat_chk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bm[i] = i[0]; ba[i] = rnd_op(); bb[i] = rnd_op(); bc[i] = rnd_op();
    end
    out_ready = 1'b0;
    idx  = 0;
    base = n_out;
    for (int cy = 0; cy < 6; cy++) begin
      mode = bm[idx]; A = ba[idx]; B = bb[idx]; C = bc[idx];
      cur_exp = model(bm[idx], ba[idx], bb[idx], bc[idx]); in_valid = 1'b1;
      tick();
      if (acc_last) idx++;
    end
    chk("accepts_while_stalled", 64'(idx), 64'(LAT));
    chk("in_ready_when_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("in_ready_full_with_out_ready", 64'(in_ready), 64'd1);
    for (int g = 0; g < 100 && idx < 10; g++) begin
      mode = bm[idx]; A = ba[idx]; B = bb[idx]; C = bc[idx];
      cur_exp = model(bm[idx], ba[idx], bb[idx], bc[idx]); in_valid = 1'b1;
      tick();
      if (acc_last) idx++;
    end
    drain();
    chk("bp_out_count", 64'(n_out - base), 64'd10);

    // Asynchronous reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      ra = rnd_op(); rb = rnd_op(); rc = rnd_op();
      send(1'(i), ra, rb, rc, model(1'(i), ra, rb, rc), 1'b0);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'd0);
    chk("async_reset_R", 64'(R), 64'd0);
    sbq.delete();
    repeat (2) tick();
    #2 rst = 1'b0;
    base = n_out;
    repeat (6) tick();
    chk("no_output_after_reset", 64'(n_out - base), 64'd0);
    lat_chk = 1'b1;
    ra = {12'd3328, 12'd3328}; rb = {12'd2, 12'd3328};
    send(1'b0, ra, rb, '0, {12'd3327, 12'd1}, 1'b0);
    drain();
    lat_chk = 1'b0;

    // Random traffic with random output stalls.
    base = n_out;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) begin
        in_valid  = 1'b0;
        out_ready = ($urandom_range(3) != 0);
        tick();
      end
      rm = 1'($urandom_range(1));
      ra = rnd_op(); rb = rnd_op(); rc = rnd_op();
      bexp = model(rm, ra, rb, rc);
      send(rm, ra, rb, rc, bexp, 1'b1);
    end
    drain();
    chk("random_out_count", 64'(n_out - base), 64'd10000);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
